mouse_pos_ctrl: RTL and testbench

MOUSE_POS_CTRL -- requirements
Module: mouse_pos_ctrl

---
 rtl/mouse_pos_ctrl.sv | 116 +++++++++++
 tb/tb_mouse_pos_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mouse_pos_ctrl.sv
// mouse_pos_ctrl: once per frame, captures a mouse position that is stable across clocks; B_left gets a synchronizer and a click detector.
// Define MOUSE_CLAMP_EN to saturate the loaded position to SCREEN_W-1 / SCREEN_H-1.
module mouse_pos_ctrl #(
    parameter int SCREEN_W   = 1024,
    parameter int SCREEN_H   = 768,
    parameter int STABLE_CNT = 2,
    parameter int MAX_RETRY  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] B_posX,
    input  logic [11:0] B_posY,
    input  logic        B_left,
    input  logic        vblank_start,
    output logic [11:0] posX,
    output logic [11:0] posY,
    output logic        pos_valid,
    output logic        sample_drop,
    output logic        left_click,
    output logic        busy
);
`ifdef MOUSE_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, SAMPLE, CHECK, LOAD} state_t;
    state_t      r_state, w_next;
    logic [11:0] r_cand_x, r_cand_y;
    logic [3:0]  r_match, r_retry;
    logic        r_s1, r_s2, r_s3;
    logic [1:0]  r_fill;
    logic        w_same, w_match_done, w_retry_done;
    logic [11:0] w_load_x, w_load_y;

    assign w_same       = (B_posX == r_cand_x) && (B_posY == r_cand_y);
    assign w_match_done = (r_match + 4'd1) == 4'(STABLE_CNT);
    assign w_retry_done = (r_retry + 4'd1) == 4'(MAX_RETRY);
    assign w_load_x     = (CLAMP && r_cand_x > 12'(SCREEN_W - 1)) ? 12'(SCREEN_W - 1) : r_cand_x;
    assign w_load_y     = (CLAMP && r_cand_y > 12'(SCREEN_H - 1)) ? 12'(SCREEN_H - 1) : r_cand_y;
    assign busy         = r_state != IDLE;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = vblank_start ? SAMPLE : IDLE;
            SAMPLE:  w_next = CHECK;
            CHECK:   w_next = w_same ? (w_match_done ? LOAD : CHECK) : (w_retry_done ? IDLE : CHECK);
            LOAD:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cand_x    <= '0;
            r_cand_y    <= '0;
            r_match     <= '0;
            r_retry     <= '0;
            posX        <= '0;
            posY        <= '0;
            pos_valid   <= 1'b0;
            sample_drop <= 1'b0;
        end else begin
            pos_valid   <= 1'b0;
            sample_drop <= 1'b0;
            case (r_state)
                SAMPLE: begin
                    r_cand_x <= B_posX;
                    r_cand_y <= B_posY;
                    r_match  <= 4'd1;
                    r_retry  <= 4'd0;
                end
                CHECK: begin
                    if (w_same) begin
                        r_match <= r_match + 4'd1;
                    end else begin
                        r_cand_x    <= B_posX;
                        r_cand_y    <= B_posY;
                        r_match     <= 4'd1;
                        r_retry     <= r_retry + 4'd1;
                        sample_drop <= w_retry_done;
                    end
                end
                LOAD: begin
                    posX      <= w_load_x;
                    posY      <= w_load_y;
                    pos_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // r_fill keeps left_click quiet until the synchronizer and edge register hold real samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_s3       <= 1'b0;
            r_fill     <= 2'd0;
            left_click <= 1'b0;
        end else begin
            r_s1       <= B_left;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            r_fill     <= (r_fill == 2'd3) ? 2'd3 : r_fill + 2'd1;
            left_click <= (r_fill == 2'd3) && r_s2 && !r_s3;
        end
    end
endmodule

// File: tb/tb_mouse_pos_ctrl.sv
// tb_mouse_pos_ctrl: randomized frames and button activity checked against a run-length reference model.
module tb_mouse_pos_ctrl;
    localparam int W = 1024, H = 768, N = 2, MR = 8;
`ifdef MOUSE_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b0;
    logic [11:0] B_posX = '0, B_posY = '0;
    logic        B_left = 1'b0, vblank_start = 1'b0;
    logic [11:0] posX, posY;
    logic        pos_valid, sample_drop, left_click, busy;
    int          tests = 0, fails = 0;
    logic [11:0] sx [64], sy [64];
    logic [11:0] exp_x = '0, exp_y = '0;

    always #5 clk = ~clk;

    mouse_pos_ctrl #(.SCREEN_W(W), .SCREEN_H(H), .STABLE_CNT(N), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst(rst), .B_posX(B_posX), .B_posY(B_posY), .B_left(B_left),
        .vblank_start(vblank_start), .posX(posX), .posY(posY), .pos_valid(pos_valid),
        .sample_drop(sample_drop), .left_click(left_click), .busy(busy)
    );

    function automatic logic [11:0] sat(input logic [11:0] v, input int m);
        return (CLAMP && int'(v) >= m) ? 12'(m - 1) : v;
    endfunction

    task automatic fill_const(input logic [11:0] x, input logic [11:0] y);
        for (int k = 0; k < 64; k++) begin sx[k] = x; sy[k] = y; end
    endtask

    // Model: scan the sample sequence for the first run of N equal samples or the MR-th change.
    task automatic run_frame(input string name, input bit noisy);
        int run, retries, ev;
        bit is_load;
        logic [11:0] cx, cy;
        cx = sx[0]; cy = sy[0]; run = 1; retries = 0; ev = 0; is_load = 0;
        for (int k = 1; k < 62 && ev == 0; k++) begin
            if (sx[k] == cx && sy[k] == cy) begin
                run++;
                if (run == N) begin ev = k + 2; is_load = 1; end
            end else begin
                cx = sx[k]; cy = sy[k]; run = 1; retries++;
                if (retries == MR) ev = k + 1;
            end
        end
        if (ev == 0) begin
            tests++; fails++;
            $display("FAIL %s model_outcome: got none want load or drop", name);
            return;
        end
        @(negedge clk); vblank_start = 1'b1; B_posX = sx[0]; B_posY = sy[0];
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL %s busy_after_vblank: got %b want 1", name, busy); end
        for (int c = 1; c <= ev; c++) begin
            @(negedge clk);
            vblank_start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            B_posX = sx[c-1]; B_posY = sy[c-1];
            @(posedge clk); #1;
            if (c == ev && is_load) begin exp_x = sat(cx, W); exp_y = sat(cy, H); end
            tests++;
            if ({pos_valid, sample_drop, busy, posX, posY} !==
                {(c == ev) && is_load, (c == ev) && !is_load, c < ev, exp_x, exp_y}) begin
                fails++;
                $display("FAIL %s cycle %0d valid/drop/busy/x/y: got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                         name, c, pos_valid, sample_drop, busy, posX, posY,
                         (c == ev) && is_load, (c == ev) && !is_load, c < ev, exp_x, exp_y);
            end
        end
        @(negedge clk); vblank_start = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({pos_valid, sample_drop, busy} !== 3'b000) begin
            fails++; $display("FAIL %s idle_after: valid/drop/busy got %b%b%b want 000", name, pos_valid, sample_drop, busy);
        end
    endtask

    task automatic test_reset();
        B_posX = 12'd55; B_posY = 12'd66;
        repeat (3) @(posedge clk);
        #1; tests++;
        if ({posX, posY, pos_valid, sample_drop, left_click, busy} !== 28'd0) begin
            fails++; $display("FAIL reset_state: got x=%0d y=%0d v=%b d=%b c=%b b=%b want all 0",
                              posX, posY, pos_valid, sample_drop, left_click, busy);
        end
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); B_posX = 12'($urandom); B_posY = 12'($urandom);
            @(posedge clk); #1; tests++;
            if ({busy, pos_valid, posX, posY} !== 26'd0) begin
                fails++; $display("FAIL idle_no_action: got busy=%b valid=%b x=%0d y=%0d want 0", busy, pos_valid, posX, posY);
            end
        end
    endtask

    task automatic test_stable(); fill_const(12'd100, 12'd200); run_frame("stable", 1'b0); endtask

    task automatic test_glitch();
        fill_const(12'd101, 12'd200); sx[0] = 12'd100;
        run_frame("glitch", 1'b0);
    endtask

    task automatic test_thrash();
        fill_const(12'd100, 12'd300);
        for (int k = 1; k < 64; k += 2) sx[k] = 12'd101;
        run_frame("thrash", 1'b0);
        fill_const(12'd300, 12'd400); run_frame("after_thrash", 1'b0);
    endtask

    task automatic test_clamp(); fill_const(12'd2000, 12'd900); run_frame("clamp", 1'b1); endtask

    task automatic test_random();
        logic [11:0] px [4], py [4];
        int idx;
        for (int f = 0; f < 25; f++) begin
            for (int p = 0; p < 4; p++) begin px[p] = 12'($urandom); py[p] = 12'($urandom); end
            for (int k = 0; k < 64; k++) begin
                idx = int'($urandom_range(0, 3));
                if (f % 2 == 0) idx = (idx < 2) ? 0 : idx - 1;
                sx[k] = px[idx]; sy[k] = py[idx];
            end
            run_frame("random", 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        fill_const(12'd77, 12'd88);
        @(negedge clk); vblank_start = 1'b1; B_posX = 12'd77; B_posY = 12'd88;
        @(negedge clk); vblank_start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0; B_left = 1'b1;
        #1; tests++; exp_x = '0; exp_y = '0;
        if ({posX, posY, pos_valid, sample_drop, left_click, busy} !== 28'd0) begin
            fails++; $display("FAIL reset_mid: got x=%0d y=%0d v=%b d=%b c=%b b=%b want all 0",
                              posX, posY, pos_valid, sample_drop, left_click, busy);
        end
        @(negedge clk); @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1; tests++;
            if ({left_click, busy} !== 2'b00) begin
                fails++; $display("FAIL click_after_reset cycle %0d: click/busy got %b%b want 00", i, left_click, busy);
            end
        end
        @(negedge clk); B_left = 1'b0;
        repeat (4) @(negedge clk);
        B_left = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk); #1; tests++;
            if (left_click !== (e == 3)) begin
                fails++; $display("FAIL click_latency edge %0d: got %b want %b", e, left_click, e == 3);
            end
        end
        run_frame("after_reset", 1'b0);
    endtask

    task automatic test_click();
        bit h [$];
        bit exp;
        repeat (4) begin @(posedge clk); h.push_back(B_left); end
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) B_left = ~B_left;
            @(posedge clk); h.push_back(B_left);
            #1; tests++;
            exp = h[h.size()-3] & ~h[h.size()-4];
            if (left_click !== exp) begin
                fails++; $display("FAIL click_random t=%0d: got %b want %b", t, left_click, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stable();
        test_glitch();
        test_thrash();
        test_clamp();
        test_random();
        test_reset_mid();
        test_click();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
